// File: rtl/playback_reader.sv
// playback_reader: streams a contiguous block of sample memory to a downstream
// consumer. The block starts at word 0 and ends at end_addr. One word is
// fetched for each sample_tick and presented on a valid/ready handshake.
//
// Memory interface: a synchronous single-port RAM. Read data appears on
// mem_dataout one cycle after mem_addr is presented. This block never
// writes, so mem_write is tied low.
//
// Optional feature: define PLAYBACK_LOOP_EN to add a `loop` input. When loop
// is high and the last word is accepted, playback restarts at address 0
// instead of finishing.
//
// Sample timing: a tick seen in ARM moves the FSM to ISSUE, then CAPTURE,
// then HOLD. sample_valid rises three cycles after the tick cycle.

module playback_reader #(
  parameter int ADDR_W = 16,  // sample memory address width
  parameter int DATA_W = 16   // sample word width
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              sample_tick,
`ifdef PLAYBACK_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // waiting for start
    ST_ARM     = 3'd1,  // waiting for the next sample tick
    ST_ISSUE   = 3'd2,  // address presented, RAM read in flight
    ST_CAPTURE = 3'd3,  // read data on mem_dataout, latch it
    ST_HOLD    = 3'd4   // sample offered downstream, waiting for ready
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_addr;        // current word address
  logic [ADDR_W-1:0] r_end;         // last address, frozen for the whole run
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;
  logic              r_done;
  logic              r_underrun;

  // Decoded one-cycle actions from the next-state logic.
  logic              w_start_ok;    // accepted start in IDLE
  logic              w_abort;       // stop in a busy state
  logic              w_capture;     // latch read data into the sample register
  logic              w_accept;      // handshake completes in HOLD
  logic              w_tick_drop;   // tick arrived while a fetch is outstanding
  logic              w_last;        // current address is the final one
  logic              w_loop;        // restart at 0 instead of finishing

`ifdef PLAYBACK_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_last = (r_addr == r_end);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is always assigned with <=. Every flop then
    // samples pre-edge values, so the order of statements cannot matter.
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and action decode. Stop overrides everything in busy states.
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would infer a latch.
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_abort      = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    w_tick_drop  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // start and stop in the same cycle: stop wins, stay idle
        if (start && !stop) begin
          w_start_ok   = 1'b1;
          w_state_next = ST_ARM;
        end
      end

      ST_ARM: begin
        if (stop) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else if (sample_tick) begin
          w_state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_tick_drop = sample_tick;
        if (stop) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        w_tick_drop = sample_tick;
        if (stop) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        w_tick_drop = sample_tick;
        if (stop) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else if (sample_ready) begin
          w_accept     = 1'b1;
          w_state_next = (w_last && !w_loop) ? ST_IDLE : ST_ARM;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: address counter, end capture, sample register and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_end      <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // done fires only on a natural finish. An abort or a loop-back
      // never produces it.
      r_done <= w_accept && w_last && !w_loop;

      if (w_start_ok) begin
        r_end      <= end_addr;
        r_underrun <= 1'b0;
      end else if (w_tick_drop) begin
        r_underrun <= 1'b1;
      end

      if (w_start_ok || w_abort) begin
        r_addr  <= '0;
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_sample <= mem_dataout;
        r_valid  <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        // Compare before incrementing, so the all-ones end never wraps.
        r_addr  <= w_last ? '0 : r_addr + 1'b1;
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_write    = 1'b0;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_playback_reader.sv
// Testbench for playback_reader: a table of per-cycle vectors plus
// hand-written multi-cycle sequences. Both memories return word[i] = i + 0x100.
// A second instance with a 10-bit address runs a complete all-ones-end sweep.
// Define PLAYBACK_LOOP_EN to include the loop sequence.

module tb_playback_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] end_addr = '0;
  logic        sample_tick = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [15:0] mem_dataout = '0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        underrun;
`ifdef PLAYBACK_LOOP_EN
  logic        loop = 1'b0;
  logic        s_loop = 1'b0;
`endif

  // Reduced-width instance used for the full address sweep.
  logic        s_start = 1'b0;
  logic        s_stop = 1'b0;
  logic [9:0]  s_end_addr = '0;
  logic        s_tick = 1'b0;
  logic [9:0]  s_mem_addr;
  logic        s_mem_write;
  logic [15:0] s_dataout = '0;
  logic [15:0] s_sample;
  logic        s_valid;
  logic        s_ready = 1'b1;
  logic        s_busy;
  logic        s_done;
  logic        s_underrun;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;

  always #5 clk = ~clk;

  playback_reader #(.ADDR_W(16), .DATA_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .end_addr(end_addr), .sample_tick(sample_tick),
`ifdef PLAYBACK_LOOP_EN
    .loop(loop),
`endif
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_dataout(mem_dataout),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .underrun(underrun)
  );

  playback_reader #(.ADDR_W(10), .DATA_W(16)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .stop(s_stop),
    .end_addr(s_end_addr), .sample_tick(s_tick),
`ifdef PLAYBACK_LOOP_EN
    .loop(s_loop),
`endif
    .mem_addr(s_mem_addr), .mem_write(s_mem_write), .mem_dataout(s_dataout),
    .sample(s_sample), .sample_valid(s_valid), .sample_ready(s_ready),
    .busy(s_busy), .done(s_done), .underrun(s_underrun)
  );

  // Synchronous-read memory models: word[i] = i + 0x100
  always @(posedge clk) begin
    mem_dataout <= mem_addr + 16'h0100;
    s_dataout   <= 16'(s_mem_addr) + 16'h0100;
  end

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock, then settle 1ns past the edge for sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Tick in ARM, check the 3-cycle latency and data, then accept (ready assumed 1)
  task automatic do_sample(input logic [15:0] exp, input string name);
    logic v2;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    v2 = sample_valid;
    cyc();
    check({name, " latency"}, {62'd0, v2, sample_valid}, 64'b01);
    check({name, " data"}, 64'(sample), 64'(exp));
    cyc();
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] end_addr;
    logic        tick;
    logic        ready;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_sample;
    logic        e_busy;
    logic        e_done;
    logic        e_und;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int d0;
    int bad;
    logic [15:0] last_s;

    // Per-cycle vectors: inputs for the cycle, expected outputs after the edge
    //            start stop end    tick ready  addr   v  sample  busy done und
    vecs[0]  = '{1'b1, 1'b0, 16'h1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h000, 1'b1, 1'b0, 1'b0}; // start -> ARM
    vecs[1]  = '{1'b0, 1'b0, 16'h1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h000, 1'b1, 1'b0, 1'b0}; // wait in ARM
    vecs[2]  = '{1'b0, 1'b0, 16'h1, 1'b1, 1'b1, 16'h0, 1'b0, 16'h000, 1'b1, 1'b0, 1'b0}; // tick -> ISSUE
    vecs[3]  = '{1'b0, 1'b0, 16'h1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h000, 1'b1, 1'b0, 1'b0}; // CAPTURE
    vecs[4]  = '{1'b0, 1'b0, 16'h1, 1'b0, 1'b1, 16'h0, 1'b1, 16'h100, 1'b1, 1'b0, 1'b0}; // HOLD valid
    vecs[5]  = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1, 1'b0, 16'h100, 1'b1, 1'b0, 1'b0}; // accept, start ignored
    vecs[6]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1, 1'b0, 16'h100, 1'b1, 1'b0, 1'b0}; // tick -> ISSUE
    vecs[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1, 1'b0, 16'h100, 1'b1, 1'b0, 1'b1}; // tick in ISSUE: underrun
    vecs[8]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h1, 1'b1, 16'h101, 1'b1, 1'b0, 1'b1}; // HOLD
    vecs[9]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h1, 1'b1, 16'h101, 1'b1, 1'b0, 1'b1}; // not ready: hold
    vecs[10] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b0, 1'b1, 1'b1}; // last accept: done
    vecs[11] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b0, 1'b0, 1'b1}; // done is one cycle
    vecs[12] = '{1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b0, 1'b0, 1'b1}; // start+stop: stay IDLE
    vecs[13] = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0}; // start clears underrun
    vecs[14] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0}; // ISSUE
    vecs[15] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0}; // CAPTURE
    vecs[16] = '{1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b0, 1'b0, 1'b0}; // stop in CAPTURE
    vecs[17] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b0, 1'b0, 1'b0}; // no done
    vecs[18] = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0}; // end=0 single sample
    vecs[19] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h101, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b1, 16'h100, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h100, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h100, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) cyc();
    check("reset outputs", {28'd0, mem_addr, sample, sample_valid, busy, done, underrun, mem_write}, 64'd0);
    reset_n = 1'b1;
    cyc();
    check("idle after reset", {62'd0, busy, s_busy}, 64'd0);

    // Table-driven per-cycle vectors
    for (int i = 0; i < 24; i++) begin
      start = vecs[i].start;
      stop = vecs[i].stop;
      end_addr = vecs[i].end_addr;
      sample_tick = vecs[i].tick;
      sample_ready = vecs[i].ready;
      cyc();
      check($sformatf("vec%0d", i),
            {27'd0, mem_addr, sample_valid, sample, busy, done, underrun, mem_write},
            {27'd0, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_sample, vecs[i].e_busy,
             vecs[i].e_done, vecs[i].e_und, 1'b0});
    end
    start = 1'b0; stop = 1'b0; sample_tick = 1'b0; sample_ready = 1'b1;
    cyc();

    // Four samples, a tick every 20 cycles, ready always high
    d0 = done_cnt;
    start = 1'b1; end_addr = 16'd3;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_sample(16'h0100 + 16'(i), $sformatf("play4 s%0d", i));
      repeat (16) cyc();
    end
    check("play4 done count", 64'(done_cnt - d0), 64'd1);
    check("play4 end state", {46'd0, busy, underrun, mem_addr}, 64'd0);

    // Ready held low for 50 cycles in HOLD while ticks keep arriving
    d0 = done_cnt;
    start = 1'b1; end_addr = 16'd2;
    cyc();
    start = 1'b0;
    sample_ready = 1'b0;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    cyc(); cyc();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      sample_tick = (i % 20 == 0);
      cyc();
      if (sample_valid !== 1'b1 || sample !== 16'h0100 || mem_addr !== 16'h0) bad++;
    end
    sample_tick = 1'b0;
    check("stall stable", 64'(bad), 64'd0);
    check("stall underrun", {63'd0, underrun}, 64'd1);
    sample_ready = 1'b1;
    cyc();
    check("stall accept", {47'd0, sample_valid, mem_addr}, 64'd1);
    do_sample(16'h0101, "stall s1");
    do_sample(16'h0102, "stall s2");
    cyc();
    check("stall done", 64'(done_cnt - d0), 64'd1);
    check("stall underrun sticky", {62'd0, underrun, busy}, 64'b10);

    // Stop while capturing the second sample
    d0 = done_cnt;
    start = 1'b1; end_addr = 16'd3;
    cyc();
    start = 1'b0;
    do_sample(16'h0100, "abort s0");
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("abort state", {46'd0, busy, sample_valid, mem_addr}, 64'd0);
    repeat (3) cyc();
    check("abort no done", 64'(done_cnt - d0), 64'd0);

    // Asynchronous reset mid-HOLD
    d0 = done_cnt;
    start = 1'b1; end_addr = 16'd3;
    cyc();
    start = 1'b0;
    sample_ready = 1'b0;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    cyc(); cyc();
    check("pre-reset hold", {63'd0, sample_valid}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset", {28'd0, mem_addr, sample, sample_valid, busy, done, underrun, mem_write}, 64'd0);
    reset_n = 1'b1;
    sample_ready = 1'b1;
    sample_tick = 1'b1;
    repeat (3) cyc();
    sample_tick = 1'b0;
    check("post-reset idle", {46'd0, busy, sample_valid, mem_addr}, 64'd0);
    check("reset no done", 64'(done_cnt - d0), 64'd0);

    // Full address range on the 10-bit instance: end = all ones
    s_start = 1'b1; s_end_addr = 10'h3FF;
    cyc();
    s_start = 1'b0;
    bad = 0;
    last_s = '0;
    for (int i = 0; i < 1024; i++) begin
      s_tick = 1'b1; cyc(); s_tick = 1'b0;
      cyc(); cyc();
      if (s_valid !== 1'b1 || s_sample !== 16'(i) + 16'h0100) bad++;
      last_s = s_sample;
      cyc();
    end
    cyc();
    check("sweep samples", 64'(bad), 64'd0);
    check("sweep last", 64'(last_s), 64'h04FF);
    check("sweep done", 64'(s_done_cnt), 64'd1);
    check("sweep end state", {52'd0, s_busy, s_underrun, s_mem_addr}, 64'd0);

`ifdef PLAYBACK_LOOP_EN
    // Looping playback with end = 1, then drop loop to finish
    d0 = done_cnt;
    loop = 1'b1;
    start = 1'b1; end_addr = 16'd1;
    cyc();
    start = 1'b0;
    do_sample(16'h0100, "loop s0");
    do_sample(16'h0101, "loop s1");
    do_sample(16'h0100, "loop s2");
    do_sample(16'h0101, "loop s3");
    check("loop no done", {31'd0, busy, 32'(done_cnt - d0)}, {31'd0, 1'b1, 32'd0});
    loop = 1'b0;
    do_sample(16'h0100, "loop s4");
    do_sample(16'h0101, "loop s5");
    cyc();
    check("loop exit", {31'd0, busy, 32'(done_cnt - d0)}, {31'd0, 1'b0, 32'd1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/playback_reader.md
PLAYBACK_READER -- requirements
Module: playback_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the sample memory address width (64K words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the sample word width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle playback request.
REQ-006 SHALL have port stop  input  1  one-cycle abort request.
REQ-007 SHALL have port end_addr  input  ADDR_W  last address to play, inclusive, captured on an accepted start.
REQ-008 SHALL have port sample_tick  input  1  one-cycle sample-rate strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  read address to sample memory.
REQ-010 SHALL have port mem_write  output  1  memory write enable, tied 0.
REQ-011 SHALL have port mem_dataout  input  DATA_W  memory read data, valid one cycle after mem_addr is presented.
REQ-012 SHALL have port sample  output  DATA_W  registered sample to downstream.
REQ-013 SHALL have port sample_valid / sample_ready  output / input  1 each  valid/ready handshake for sample.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the end_addr sample is accepted.
REQ-016 SHALL have port underrun  output  1  sticky flag: sample_tick arrived while previous sample not yet accepted.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, ISSUE, CAPTURE, HOLD.
REQ-018 IDLE: on start with stop low, addr<=0, end register<=end_addr, underrun<=0, go ARM; start in any other state SHALL be ignored.
REQ-019 ARM: on sample_tick go ISSUE; otherwise remain.
REQ-020 ISSUE: mem_addr holds addr for exactly one cycle (SPRAM read latency); go CAPTURE.
REQ-021 CAPTURE: sample<=mem_dataout, sample_valid<=1, go HOLD; sample tick-to-valid latency SHALL be 3 cycles.
REQ-022 HOLD: sample and sample_valid stable until sample_ready high; on that cycle sample_valid<=0.
REQ-023 HOLD accept with addr != end: addr<=addr+1, go ARM.
REQ-024 HOLD accept with addr == end: done pulses next cycle, go IDLE, addr<=0.
REQ-025 mem_addr SHALL always equal the internal addr register; mem_write SHALL always be 0.
REQ-026 sample_tick in ISSUE, CAPTURE or HOLD SHALL set underrun and be otherwise dropped (no queued fetch).
REQ-027 stop in any non-IDLE state SHALL force IDLE next cycle: sample_valid 0, addr 0, no done pulse; stop and start same cycle: stop wins.
REQ-028 end_addr = 0xFFFF SHALL play all 65536 words and terminate without address wrap; end_addr = 0 plays one sample.
REQ-029 Changes to end_addr while busy SHALL have no effect.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, mem_addr 0, sample 0, sample_valid 0, busy 0, done 0, underrun 0, mem_write 0.
REQ-031 Reset mid-playback SHALL abandon the transfer without a done pulse; first action after release requires a new start.

Configuration
REQ-032 Macro PLAYBACK_LOOP_EN defined: SHALL add input port loop (1 bit); HOLD accept at end with loop high SHALL set addr<=0 and go ARM without done pulse; loop low behaves as REQ-024.
REQ-033 Macro PLAYBACK_LOOP_EN undefined: no loop port; playback always terminates per REQ-024.

Verification
REQ-034 Memory model preloaded word[i]=i+0x100, end_addr=3, start, tick every 20 cycles, ready=1 -> samples 0x100,0x101,0x102,0x103 each 3 cycles after tick, done one pulse, busy low after.
REQ-035 ready held low 50 cycles in HOLD with ticks every 20 -> sample/valid stable, underrun=1, no address skipped once ready returns.
REQ-036 stop asserted in CAPTURE of second sample -> next cycle IDLE, sample_valid 0, mem_addr 0, no done.
REQ-037 end_addr=0xFFFF, ticks every 4 cycles, ready=1 -> 65536 samples, last from 0xFFFF, done once, mem_addr returns to 0.
REQ-038 reset_n pulsed low asynchronously mid-HOLD -> all outputs at reset values before next clk edge; start+stop same cycle in IDLE -> stays IDLE.
REQ-039 With PLAYBACK_LOOP_EN, loop=1, end_addr=1 -> sample sequence 0x100,0x101,0x100,0x101..., no done; loop dropped to 0 -> done after next 0x101 accept.
